// File: rtl/vctr_fifo_driver.sv
// vctr_fifo_driver: streams 2*VECTOR_LENGTH operand words into the vector FIFO
//   accelerator, then drains VECTOR_LENGTH results onto a valid/ready stream.
// Latency: operand words pass to acc_data_in combinationally; each result
//   takes 3 cycles (RD_REQ, RD_CAP, OUT) when m_ready is held high.
// Backpressure: s_ready follows acc_ready only while loading. m_valid/m_data
//   hold steady in OUT until m_ready.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   s_valid/s_ready/s_data         upstream operand stream
//   m_valid/m_ready/m_data         downstream result stream
//   acc_*                          accelerator control and data handshake
//   busy, err, job_count           status: not idle, sticky timeout, jobs completed
module vctr_fifo_driver #(
  parameter int DATA_WIDTH     = 16,
  parameter int VECTOR_LENGTH  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  acc_start,
  input  logic                  acc_idle,
  input  logic                  acc_ready,
  input  logic                  acc_done,
  output logic                  acc_data_in_en,
  output logic [DATA_WIDTH-1:0] acc_data_in,
  output logic                  acc_data_out_en,
  input  logic [DATA_WIDTH-1:0] acc_data_out,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           job_count
);

  localparam int CW = $clog2(2*VECTOR_LENGTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CW-1:0] IN_LAST  = CW'(2*VECTOR_LENGTH-1);
  localparam logic [CW-1:0] OUT_LAST = CW'(VECTOR_LENGTH-1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE, START, LOAD, WAIT_DONE, RD_REQ, RD_CAP, OUT, FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   in_cnt, out_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            in_hs, out_hs, job_done, abort, tmo_hit, tmo_run;

  // tmo_cnt holds the number of cycles already spent in the current
  // WAIT_DONE/FINISH visit, so the abort fires at the end of cycle N.
  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign tmo_run = (state == WAIT_DONE) || (state == FINISH);
  assign m_valid = (state == OUT);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt       = state;
    s_ready         = 1'b0;
    acc_start       = 1'b0;
    acc_data_in_en  = 1'b0;
    acc_data_in     = '0;
    acc_data_out_en = 1'b0;
    in_hs           = 1'b0;
    out_hs          = 1'b0;
    job_done        = 1'b0;
    abort           = 1'b0;
    case (state)
      IDLE: begin
        // The first word is only observed here; it is consumed in LOAD.
        if (s_valid && acc_idle) state_nxt = START;
      end
      START: begin
        acc_start = 1'b1;
        if (acc_ready) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready        = acc_ready;
        in_hs          = s_valid && acc_ready;
        acc_data_in_en = in_hs;
        acc_data_in    = s_data;
        if (in_hs && (in_cnt == IN_LAST)) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (acc_done) begin
          state_nxt = RD_REQ;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_REQ: begin
        acc_data_out_en = 1'b1;
        state_nxt       = RD_CAP;
      end
      RD_CAP: begin
        // acc_data_out is valid this cycle; it is registered into m_data.
        state_nxt = OUT;
      end
      OUT: begin
        out_hs = m_ready;
        if (m_ready) state_nxt = (out_cnt == OUT_LAST) ? FINISH : RD_REQ;
      end
      FINISH: begin
        if (acc_idle) begin
          job_done  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      tmo_cnt   <= '0;
      m_data    <= '0;
      err       <= 1'b0;
      job_count <= '0;
    end else begin
      state <= state_nxt;

      if (abort) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        err     <= 1'b1;
      end else begin
        if (in_hs)  in_cnt  <= (in_cnt  == IN_LAST)  ? '0 : in_cnt  + CW'(1);
        if (out_hs) out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + CW'(1);
      end

      // Restart the timeout on every state change, count only while waiting.
      if (!tmo_run || (state_nxt != state)) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TW'(1);

      if (state == RD_CAP) m_data <= acc_data_out;

      if (job_done) job_count <= job_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vctr_fifo_driver.sv
// tb_vctr_fifo_driver: drives operand jobs into vctr_fifo_driver against a
//   behavioural vector-add accelerator and scoreboards the result stream.
// Expected results are queued when a job is driven and popped on m_data.
module tb_vctr_fifo_driver;

  localparam int DW = 16;
  localparam int VL = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic          acc_start, acc_idle, acc_ready, acc_done;
  logic          acc_data_in_en, acc_data_out_en;
  logic [DW-1:0] acc_data_in, acc_data_out;
  logic          busy, err;
  logic [15:0]   job_count;

  always #5 clk = ~clk;

  vctr_fifo_driver #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .acc_start(acc_start), .acc_idle(acc_idle), .acc_ready(acc_ready), .acc_done(acc_done),
    .acc_data_in_en(acc_data_in_en), .acc_data_in(acc_data_in),
    .acc_data_out_en(acc_data_out_en), .acc_data_out(acc_data_out),
    .busy(busy), .err(err), .job_count(job_count)
  );

  // ---------------- accelerator model: element-wise add of two vectors ----
  logic          acc_stall   = 1'b0;  // randomly drop acc_ready while loading
  logic          acc_no_done = 1'b0;  // swallow the job, never raise acc_done
  logic [DW-1:0] a_mem [0:2*VL-1];
  int            a_st, a_cnt, a_dly;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_st <= 0; a_cnt <= 0; a_dly <= 0;
      acc_idle <= 1'b1; acc_ready <= 1'b0; acc_done <= 1'b0; acc_data_out <= '0;
    end else begin
      case (a_st)
        0: if (acc_start) begin
             a_st <= 1; acc_idle <= 1'b0; acc_ready <= 1'b1; a_cnt <= 0;
           end
        1: begin
             if (acc_data_in_en) begin
               a_mem[a_cnt] <= acc_data_in;
               a_cnt <= a_cnt + 1;
             end
             if (acc_data_in_en && a_cnt == 2*VL-1) begin
               acc_ready <= 1'b0; a_dly <= 0;
               if (acc_no_done) begin a_st <= 0; acc_idle <= 1'b1; end
               else a_st <= 2;
             end else begin
               acc_ready <= acc_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
             end
           end
        2: begin
             a_dly <= a_dly + 1;
             if (a_dly == 3) begin acc_done <= 1'b1; a_cnt <= 0; a_st <= 3; end
           end
        3: if (acc_data_out_en) begin
             acc_data_out <= a_mem[a_cnt] + a_mem[a_cnt+VL];
             a_cnt <= a_cnt + 1;
             if (a_cnt == VL-1) begin acc_done <= 1'b0; a_dly <= 0; a_st <= 4; end
           end
        default: begin
             a_dly <= a_dly + 1;
             if (a_dly == 2) begin acc_idle <= 1'b1; a_st <= 0; end
           end
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {9'b0, s_ready, m_valid, m_data, acc_start, acc_data_in_en, acc_data_in,
            acc_data_out_en, busy, err, job_count};
  endfunction

  // ---------------- monitors / scoreboard (sampled on negedge) ------------
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] stim [0:2*VL-1];
  int in_en_cnt = 0, out_en_cnt = 0, ready_viol = 0, start_cnt = 0, results_seen = 0;
  logic start_prev = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (acc_data_in_en) begin
      in_en_cnt++;
      if (!acc_ready) ready_viol++;
    end
    if (acc_data_out_en) out_en_cnt++;
    if (acc_start && !start_prev) start_cnt++;
    start_prev = acc_start;
    if (m_valid && m_ready) begin
      results_seen++;
      exp_w = 'x;
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      check_eq("m_data", 64'(m_data), 64'(exp_w));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_expected();
    logic [DW-1:0] s;
    for (int i = 0; i < VL; i++) begin
      s = stim[i] + stim[i+VL];
      exp_q.push_back(s);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    check_eq("word_accepted", 64'(ok), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic load_words(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      push_word(stim[i]);
      if (gaps) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_quiet(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check_eq(tag, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    logic [15:0] jc0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;

    #1 check_eq("reset_outputs", outs_vec(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic job: 1..16 -> 10,12,...,24
    for (int i = 0; i < 2*VL; i++) stim[i] = DW'(i + 1);
    push_expected();
    in_en_cnt = 0; out_en_cnt = 0;
    load_words(0, 2*VL-1, 1'b0);
    wait_quiet("basic_done");
    check_eq("basic_job_count", 64'(job_count), 64'd1);
    check_eq("basic_busy", 64'(busy), 64'd0);
    check_eq("basic_err", 64'(err), 64'd0);
    check_eq("basic_in_en", 64'(in_en_cnt), 64'd16);
    check_eq("basic_out_en", 64'(out_en_cnt), 64'd8);

    // Input gaps with accelerator stalls
    acc_stall = 1'b1;
    push_expected();
    in_en_cnt = 0; ready_viol = 0;
    load_words(0, 2*VL-1, 1'b1);
    wait_quiet("gaps_done");
    acc_stall = 1'b0;
    check_eq("gaps_in_en", 64'(in_en_cnt), 64'd16);
    check_eq("gaps_en_while_not_ready", 64'(ready_viol), 64'd0);
    check_eq("gaps_job_count", 64'(job_count), 64'd2);

    // Output backpressure on the third result
    push_expected();
    out_en_cnt = 0; results_seen = 0;
    load_words(0, 2*VL-1, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (results_seen == 2) begin ok = 1'b1; break; end
    end
    check_eq("bp_two_results", 64'(ok), 64'd1);
    @(posedge clk); #1 m_ready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_valid) begin ok = 1'b1; break; end
    end
    check_eq("bp_third_valid", 64'(ok), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_hold_valid", 64'(m_valid), 64'd1);
      check_eq("bp_hold_data", 64'(m_data), 64'd14);
      @(negedge clk);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_quiet("bp_done");
    check_eq("bp_out_en", 64'(out_en_cnt), 64'd8);
    check_eq("bp_job_count", 64'(job_count), 64'd3);

    // Wrap: 0xFFFF + 0x0002 -> 0x0001, two back-to-back jobs
    for (int i = 0; i < VL; i++) begin stim[i] = 16'hFFFF; stim[i+VL] = 16'h0002; end
    jc0 = job_count;
    push_expected();
    load_words(0, 2*VL-1, 1'b0);
    push_expected();
    start_cnt = 0; results_seen = 0;
    push_word(stim[0]);  // 17th word: must wait for the second job's START
    check_eq("wrap_17th_after_start", 64'(start_cnt), 64'd1);
    check_eq("wrap_17th_after_drain", 64'(results_seen), 64'd8);
    load_words(1, 2*VL-1, 1'b0);
    wait_quiet("wrap_done");
    check_eq("wrap_jobs", 64'(job_count - jc0), 64'd2);

    // Timeout: accelerator never raises acc_done
    acc_no_done = 1'b1;
    jc0 = job_count;
    load_words(0, 2*VL-1, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check_eq("tmo_err_before", 64'(err), 64'd0);
    check_eq("tmo_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_eq("tmo_err", 64'(err), 64'd1);
    check_eq("tmo_idle", 64'(busy), 64'd0);
    check_eq("tmo_job_count", 64'(job_count), 64'(jc0));
    acc_no_done = 1'b0;

    // Reset in the middle of LOAD
    for (int i = 0; i < 2*VL; i++) stim[i] = DW'(16'h0100 + 16'(i * 3));
    load_words(0, 4, 1'b0);
    check_eq("rst_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1; s_valid = 1'b1; s_data = 16'hA5A5;
    #1 check_eq("rst_mid_load_outputs", outs_vec(), 64'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_expected();
    load_words(0, 2*VL-1, 1'b0);
    wait_quiet("post_rst_done");
    check_eq("post_rst_job_count", 64'(job_count), 64'd1);
    check_eq("post_rst_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vctr_fifo_driver.md
Name: vctr_fifo_driver

Overview:
- Initiator-side controller for the vector FIFO accelerator (start/idle/ready/done plus serial data_in/data_out ports).
- Accepts a valid/ready input stream of operand words and runs one accelerator job per 2*VECTOR_LENGTH words: vector 1 first, then vector 2.
- Drains the VECTOR_LENGTH result words and presents them on a valid/ready output stream.
- Sits between the system-side streaming fabric and the accelerator instance.

Parameters:
- DATA_WIDTH, 16, word width; must match the accelerator.
- VECTOR_LENGTH, 8, words per vector; must match the accelerator.
- TIMEOUT_CYCLES, 1024, max cycles spent in WAIT_DONE or FINISH before aborting.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream operand word valid.
- s_ready  out  1  upstream operand word accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  operand word.
- m_valid  out  1  result word valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  DATA_WIDTH  result word.
- acc_start  out  1  accelerator start pulse.
- acc_idle  in  1  accelerator idle.
- acc_ready  in  1  accelerator accepting input words.
- acc_done  in  1  accelerator results available.
- acc_data_in_en  out  1  accelerator input write enable.
- acc_data_in  out  DATA_WIDTH  accelerator input word.
- acc_data_out_en  out  1  accelerator output read enable.
- acc_data_out  in  DATA_WIDTH  accelerator output word; valid the cycle after acc_data_out_en.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; cleared only by rst.
- job_count  out  16  completed jobs; wraps at 0xFFFF to 0.

Behaviour:
- Reset values (asynchronous): state=IDLE; all outputs 0; word counters 0; m_data 0.
- States: IDLE, START, LOAD, WAIT_DONE, RD_REQ, RD_CAP, OUT, FINISH.
- IDLE
  - s_ready=0.
  - Moves to START when s_valid && acc_idle.
  - No word is consumed on this transition.
- START
  - acc_start=1 every cycle in this state.
  - Moves to LOAD on the first cycle acc_ready=1.
- LOAD
  - s_ready = acc_ready.
  - acc_data_in_en = s_valid && acc_ready.
  - acc_data_in = s_data, combinational pass-through, zero latency.
  - in_cnt increments on each handshake.
  - s_valid gaps are allowed and hold the count.
  - Moves to WAIT_DONE on the handshake that makes in_cnt reach 2*VECTOR_LENGTH; in_cnt then clears.
  - Words beyond 2*VECTOR_LENGTH are never accepted in the same job.
- WAIT_DONE
  - Moves to RD_REQ when acc_done=1.
  - The timeout counter starts at entry.
- RD_REQ
  - acc_data_out_en=1 for exactly one cycle, then RD_CAP.
- RD_CAP
  - Registers acc_data_out into m_data.
  - m_valid=1 from the next cycle; moves to OUT.
- OUT
  - Holds m_valid and m_data stable until m_ready.
  - On handshake, out_cnt increments and m_valid drops.
  - Moves to FINISH if out_cnt reaches VECTOR_LENGTH (out_cnt clears), else back to RD_REQ.
  - Throughput is 1 result per 3 cycles with m_ready held high.
- FINISH
  - Moves to IDLE when acc_idle=1; job_count increments on that transition.
- Timeout
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle in WAIT_DONE/FINISH; resets on state entry.
  - On reaching TIMEOUT_CYCLES: err=1, state goes to IDLE, counters clear, job_count unchanged.
- Arithmetic
  - No arithmetic on data; words pass bit-exact.
  - Counter widths are $clog2(2*VECTOR_LENGTH+1).
- Reset mid-operation
  - All outputs drop to 0 within the asserted cycle (async).
  - A partially loaded job is lost.
  - The accelerator is reset by the same system reset.
- Simultaneous events
  - In OUT, m_ready is honoured in the same cycle m_valid is high.
  - A simultaneous s_valid in FINISH is ignored until IDLE.

Test Plan:
- Basic job: VL=8, DW=16, stream words 1..16 back-to-back, m_ready=1 → m_data sequence 10,12,14,16,18,20,22,24; job_count=1; busy low after FINISH; err=0.
- Input gaps: same 16 words with s_valid toggling every other cycle → identical outputs; exactly 16 acc_data_in_en pulses, none while acc_ready=0.
- Output backpressure: m_ready low for 5 cycles on the 3rd result → m_valid stays 1 and m_data stays 14 throughout; exactly 8 acc_data_out_en pulses in total.
- Wrap: vector1 all 0xFFFF, vector2 all 0x0002 → all results 0x0001; two consecutive jobs → job_count=2; 17th s_valid word is not accepted until the second START.
- Timeout: acc_done tied 0 after load, TIMEOUT_CYCLES=16 → err=1 after 16 WAIT_DONE cycles; return to IDLE; job_count stays 0.
- Reset mid-LOAD: assert rst after 5 words → all outputs 0 immediately; a fresh 16-word job afterwards produces correct results.
